// File: rtl/athos_pkg.sv
// Shared Kyber datapath constants, FSM state type and the message-bit
// to coefficient mapping used by the message expansion logic.
package athos_pkg;

  localparam int KYBER_HALF_Q = 1665;  // (q + 1) / 2 with q = 3329
  localparam int MSG_WORDS    = 8;     // 32-bit words per 256-bit message
  localparam int COEFF_IDX_W  = 8;     // index width for 256 coefficients

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } frommsg_state_e;

  // A set message bit maps to (q+1)/2, a clear bit to 0.
  // The negation builds an all-ones or all-zeros mask from the bit.
  function automatic logic [15:0] frommsg_coeff(input logic msg_bit);
    return (-{15'd0, msg_bit}) & 16'(KYBER_HALF_Q);
  endfunction

endpackage

// File: rtl/poly_msg_word_buf.sv
// Two-entry message word buffer. "cur" is the word whose bits are being
// expanded; "nxt" holds the following word so there is no bubble when the
// expander moves from one word to the next.
module poly_msg_word_buf #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] push_word,
  output logic [WORD_W-1:0] cur_word,
  output logic              cur_valid,
  output logic              nxt_valid
);

  logic [WORD_W-1:0] nxt_word;

  // Word storage: pushes fill cur first, pops promote nxt into cur.
  // A push coinciding with a pop while nxt is empty lands straight in cur.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_word  <= '0;
      nxt_word  <= '0;
      cur_valid <= 1'b0;
      nxt_valid <= 1'b0;
    end else if (clear) begin
      cur_word  <= '0;
      nxt_word  <= '0;
      cur_valid <= 1'b0;
      nxt_valid <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!cur_valid) begin
            cur_word  <= push_word;
            cur_valid <= 1'b1;
          end else begin
            nxt_word  <= push_word;
            nxt_valid <= 1'b1;
          end
        end
        2'b01: begin
          if (nxt_valid) begin
            cur_word  <= nxt_word;
            nxt_valid <= 1'b0;
          end else begin
            cur_valid <= 1'b0;
          end
        end
        2'b11: begin
          if (nxt_valid) begin
            cur_word <= nxt_word;
            nxt_word <= push_word;
          end else begin
            cur_word <= push_word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/poly_frommsg_stream.sv
// Streaming message-to-polynomial expander. Message words arrive over a
// valid/ready input; one coefficient (0 or (q+1)/2) leaves per output
// handshake, in bit order: word 0 bit 0 is coefficient 0.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. Valid never depends on ready on the same side and,
// once raised, valid and data hold until the transfer. Both ready and
// valid outputs here decode registered state only.
module poly_frommsg_stream
  import athos_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int COEFF_W  = 16,
  parameter int N_COEFFS = 256,
  parameter int HALF_Q   = KYBER_HALF_Q
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   clear_i,
  input  logic                   msg_valid_i,
  output logic                   msg_ready_o,
  input  logic [WORD_W-1:0]      msg_word_i,
  output logic                   coeff_valid_o,
  input  logic                   coeff_ready_i,
  output logic [COEFF_W-1:0]     coeff_o,
  output logic [COEFF_IDX_W-1:0] coeff_idx_o,
  output logic                   last_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int BIT_W   = $clog2(WORD_W);
  localparam int WORD_CW = COEFF_IDX_W - BIT_W;
  localparam int N_WORDS = N_COEFFS / WORD_W;

  frommsg_state_e     state_q, state_d;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [WORD_CW-1:0] word_cnt_q;
  logic [3:0]         words_acc_q;
  logic               done_q;

  logic [WORD_W-1:0]  cur_word;
  logic               cur_valid;
  logic               nxt_valid;

  logic               run;
  logic               start_accept;
  logic               msg_hs;
  logic               coeff_hs;
  logic               wrap;

  assign run          = (state_q == ST_RUN);
  assign start_accept = !run && start_i && !clear_i;

  assign msg_ready_o  = run && !nxt_valid && (words_acc_q < 4'(N_WORDS));
  assign msg_hs       = msg_valid_i && msg_ready_o;

  assign coeff_valid_o = cur_valid;
  assign coeff_hs      = cur_valid && coeff_ready_i;
  assign wrap          = coeff_hs && (bit_cnt_q == '1);

  assign coeff_idx_o = {word_cnt_q, bit_cnt_q};
  assign coeff_o     = {COEFF_W{cur_word[bit_cnt_q]}} & COEFF_W'(HALF_Q);
  assign last_o      = cur_valid && (coeff_idx_o == '1);
  assign busy_o      = run;
  assign done_o      = done_q;

  poly_msg_word_buf #(
    .WORD_W(WORD_W)
  ) u_buf (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .clear     (clear_i || start_accept),
    .push      (msg_hs),
    .pop       (wrap),
    .push_word (msg_word_i),
    .cur_word  (cur_word),
    .cur_valid (cur_valid),
    .nxt_valid (nxt_valid)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: clear wins over everything, the last coefficient ends RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i && !clear_i) state_d = ST_RUN;
      ST_RUN: begin
        if (clear_i)                  state_d = ST_IDLE;
        else if (coeff_hs && last_o)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit/word/accepted-word counters and the registered done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      words_acc_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= run && !clear_i && coeff_hs && last_o;
      if (clear_i || start_accept) begin
        bit_cnt_q   <= '0;
        word_cnt_q  <= '0;
        words_acc_q <= '0;
      end else begin
        if (coeff_hs) begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == '1) word_cnt_q <= word_cnt_q + 1'b1;
        end
        if (msg_hs) words_acc_q <= words_acc_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_poly_frommsg_stream.sv
// Directed + randomized bench for poly_frommsg_stream. Expected coefficients
// come from the message words directly: coefficient i is bit (i mod 32) of
// word (i / 32), mapped to 1665 when set.
module tb_poly_frommsg_stream;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        clear;
  logic        msg_valid;
  logic        msg_ready;
  logic [31:0] msg_word;
  logic        coeff_valid;
  logic        coeff_ready;
  logic [15:0] coeff;
  logic [7:0]  coeff_idx;
  logic        last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [31:0] msg_words [8];
  int          bubbles;
  bit          aborted;

  poly_frommsg_stream dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .clear_i       (clear),
    .msg_valid_i   (msg_valid),
    .msg_ready_o   (msg_ready),
    .msg_word_i    (msg_word),
    .coeff_valid_o (coeff_valid),
    .coeff_ready_i (coeff_ready),
    .coeff_o       (coeff),
    .coeff_idx_o   (coeff_idx),
    .last_o        (last),
    .busy_o        (busy),
    .done_o        (done)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: coefficient value for message bit i.
  function automatic logic [15:0] ref_coeff(input int i);
    logic [31:0] w;
    w = msg_words[i / 32];
    return ((w >> (i % 32)) & 32'd1) != 0 ? 16'd1665 : 16'd0;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_msg_ready"}, msg_ready, 0);
    chk({tag, "_coeff_valid"}, coeff_valid, 0);
    chk({tag, "_coeff"}, coeff, 0);
    chk({tag, "_idx"}, coeff_idx, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic rand_words();
    for (int i = 0; i < 8; i++) msg_words[i] = $urandom;
  endtask

  task automatic start_msg();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
  endtask

  // Driver + scoreboard for one message. Words are offered from msg_words
  // with 'gap' idle cycles after each accepted word; coeff_ready is high
  // with probability ready_pct. Stops early when abort_at coefficients
  // have been consumed.
  task automatic run_msg(input int ready_pct, input int gap, input int abort_at,
                         input bit start_noise, output int bub, output bit abrt);
    logic [15:0] exp_q[$];
    int          exp_idx, wi, gap_cnt, cycles, first_hs;
    bit          seen_valid, stalled;
    logic [15:0] p_coeff;
    logic [7:0]  p_idx;
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(ref_coeff(i));
    exp_idx = 0; wi = 0; gap_cnt = 0; cycles = 0; first_hs = -10;
    seen_valid = 0; stalled = 0; bub = 0; abrt = 0;
    p_coeff = '0; p_idx = '0;
    while (exp_idx < 256 && cycles < 4000) begin
      if (exp_idx == abort_at) begin
        abrt = 1;
        break;
      end
      msg_valid   = (wi < 8) && (gap_cnt == 0);
      msg_word    = msg_words[wi % 8];
      coeff_ready = ($urandom_range(99) < ready_pct);
      start       = start_noise ? ($urandom_range(3) == 0) : 1'b0;
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      if (cycles == first_hs + 1) chk("latency", coeff_valid, 1);
      if (wi == 8) chk("rdy_after8", msg_ready, 0);
      if (stalled && coeff_valid) begin
        chk("hold_coeff", coeff, p_coeff);
        chk("hold_idx", coeff_idx, p_idx);
      end
      if (coeff_valid) begin
        seen_valid = 1;
        if (coeff_ready) begin
          chk("coeff", coeff, exp_q.pop_front());
          chk("idx", coeff_idx, exp_idx);
          chk("last", last, exp_idx == 255);
          exp_idx++;
        end
      end else begin
        chk("last_idle", last, 0);
        if (seen_valid) bub++;
      end
      stalled = coeff_valid && !coeff_ready;
      p_coeff = coeff;
      p_idx   = coeff_idx;
      if (msg_valid && msg_ready) begin
        if (first_hs < 0) first_hs = cycles;
        wi++;
        gap_cnt = gap;
      end else if (gap_cnt > 0) begin
        gap_cnt--;
      end
      step();
      cycles++;
    end
    msg_valid   = 1'b0;
    coeff_ready = 1'b0;
    start       = 1'b0;
    if (!abrt) chk("msg_complete", exp_idx, 256);
  endtask

  task automatic chk_done();
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0;
    msg_valid = 1'b0; msg_word = '0; coeff_ready = 1'b0;
    repeat (3) step();
    chk_quiet("reset");
    rst_n = 1'b1;
    repeat (3) step();
    chk_quiet("idle");

    // Directed full message, no stalls.
    msg_words[0] = 32'h0000_0001; msg_words[1] = 32'h8000_0000;
    msg_words[2] = 32'hFFFF_FFFF; msg_words[3] = 32'h0000_0000;
    msg_words[4] = 32'hAAAA_AAAA; msg_words[5] = 32'h5555_5555;
    msg_words[6] = 32'h0F0F_0F0F; msg_words[7] = 32'h1234_5678;
    start_msg();
    run_msg(100, 0, -1, 0, bubbles, aborted);
    chk("nostall_bubbles", bubbles, 0);
    chk_done();
    step();
    chk("done_one_cycle", done, 0);

    // Backpressure with a 0x3 first word.
    rand_words();
    msg_words[0] = 32'h0000_0003;
    start_msg();
    run_msg(50, 0, -1, 0, bubbles, aborted);
    chk_done();
    step();

    // Starved input: long gaps between words empty the buffer.
    rand_words();
    start_msg();
    run_msg(100, 40, -1, 0, bubbles, aborted);
    chk("starved_bubbles", bubbles > 0, 1);
    chk_done();
    step();

    // Abort at index 100, then a fresh message restarts at 0.
    rand_words();
    start_msg();
    run_msg(100, 0, 100, 0, bubbles, aborted);
    chk("abort_reached", aborted, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", coeff_valid, 0);
    chk("abort_ready", msg_ready, 0);
    chk("abort_done", done, 0);
    step();
    chk("abort_done2", done, 0);
    rand_words();
    start_msg();
    run_msg(80, 0, -1, 0, bubbles, aborted);
    chk_done();
    step();

    // start while busy is ignored; start with done begins a new message.
    rand_words();
    start_msg();
    run_msg(70, 0, -1, 1, bubbles, aborted);
    chk_done();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("chain_busy", busy, 1);
    chk("chain_done", done, 0);
    rand_words();
    run_msg(100, 0, -1, 0, bubbles, aborted);
    chk("chain_bubbles", bubbles, 0);
    chk_done();
    step();

    // Asynchronous reset in the middle of a message.
    rand_words();
    start_msg();
    run_msg(100, 0, 50, 0, bubbles, aborted);
    chk("midreset_reached", aborted, 1);
    rst_n = 1'b0;
    #1;
    chk_quiet("midreset");
    step();
    rst_n = 1'b1;
    repeat (2) step();
    chk_quiet("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
